// File: rtl/int_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : int_sequencer_if
// Purpose  : Control-unit <-> interrupt sequencer signal bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface int_sequencer_if;
    logic       intr_in;
    logic       sei;
    logic       cli;
    logic       retie;
    logic       exec_done;
    logic       int_en;
    logic       int_pending;
    logic       cu_hold;
    logic       scr_we;
    logic       scr_data_sel;
    logic [1:0] scr_addr_sel;
    logic       sp_decr;
    logic       pc_ld;
    logic [1:0] pc_mux_sel;
    logic       flg_shad_ld;
    logic       flg_clr;

    modport slave (
        input  intr_in, sei, cli, retie, exec_done,
        output int_en, int_pending, cu_hold, scr_we, scr_data_sel, scr_addr_sel,
               sp_decr, pc_ld, pc_mux_sel, flg_shad_ld, flg_clr
    );

    modport master (
        output intr_in, sei, cli, retie, exec_done,
        input  int_en, int_pending, cu_hold, scr_we, scr_data_sel, scr_addr_sel,
               sp_decr, pc_ld, pc_mux_sel, flg_shad_ld, flg_clr
    );
endinterface
`default_nettype wire

// File: rtl/int_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : int_sequencer
// Purpose  : Interrupt request latch, enable mask and two-cycle entry sequence.
// Revision : 1.0 - initial release
// ============================================================================
module int_sequencer (
    input  wire logic      clk,
    input  wire logic      reset,
    int_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAVE   = 2'd1,
        ST_VECTOR = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_sync3;
    logic       r_warm;
    logic       r_armed;
    logic       r_int_en;
    logic       r_int_pending;
    logic       r_cu_hold;
    logic       r_scr_we;
    logic       r_scr_data_sel;
    logic [1:0] r_scr_addr_sel;
    logic       r_sp_decr;
    logic       r_pc_ld;
    logic [1:0] r_pc_mux_sel;
    logic       r_flg_shad_ld;
    logic       r_flg_clr;

    logic       w_edge;
    logic       w_start;

    // r_armed only goes high once the real pin has been seen low after reset,
    // so a level already high at reset release never looks like a new edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_warm  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= bus.intr_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_warm  <= 1'b1;
            r_armed <= r_armed | (r_warm & ~r_sync1);
        end
    end

    assign w_edge  = r_sync2 & ~r_sync3 & r_armed;
    assign w_start = (r_state == ST_IDLE) & bus.exec_done & r_int_pending & r_int_en;

    // Outputs are loaded together with the state they belong to, so each one
    // is a pure function of the current state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_int_en       <= 1'b0;
            r_int_pending  <= 1'b0;
            r_cu_hold      <= 1'b0;
            r_scr_we       <= 1'b0;
            r_scr_data_sel <= 1'b0;
            r_scr_addr_sel <= 2'd0;
            r_sp_decr      <= 1'b0;
            r_pc_ld        <= 1'b0;
            r_pc_mux_sel   <= 2'd0;
            r_flg_shad_ld  <= 1'b0;
            r_flg_clr      <= 1'b0;
        end else begin
            // A new edge wins over the clear that happens on leaving SAVE.
            r_int_pending  <= w_edge | (r_int_pending & (r_state != ST_SAVE));

            r_cu_hold      <= 1'b0;
            r_scr_we       <= 1'b0;
            r_scr_data_sel <= 1'b0;
            r_scr_addr_sel <= 2'd0;
            r_sp_decr      <= 1'b0;
            r_pc_ld        <= 1'b0;
            r_pc_mux_sel   <= 2'd0;
            r_flg_shad_ld  <= 1'b0;
            r_flg_clr      <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.cli) begin
                        r_int_en <= 1'b0;
                    end else if (bus.sei || bus.retie) begin
                        r_int_en <= 1'b1;
                    end
                    if (w_start) begin
                        r_state        <= ST_SAVE;
                        r_cu_hold      <= 1'b1;
                        r_scr_we       <= 1'b1;
                        r_scr_data_sel <= 1'b1;
                        r_scr_addr_sel <= 2'd3;
                        r_sp_decr      <= 1'b1;
                        r_flg_shad_ld  <= 1'b1;
                    end
                end
                ST_SAVE: begin
                    r_state      <= ST_VECTOR;
                    r_cu_hold    <= 1'b1;
                    r_pc_ld      <= 1'b1;
                    r_pc_mux_sel <= 2'd2;
                    r_flg_clr    <= 1'b1;
                end
                ST_VECTOR: begin
                    r_state  <= ST_IDLE;
                    r_int_en <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.int_en       = r_int_en;
    assign bus.int_pending  = r_int_pending;
    assign bus.cu_hold      = r_cu_hold;
    assign bus.scr_we       = r_scr_we;
    assign bus.scr_data_sel = r_scr_data_sel;
    assign bus.scr_addr_sel = r_scr_addr_sel;
    assign bus.sp_decr      = r_sp_decr;
    assign bus.pc_ld        = r_pc_ld;
    assign bus.pc_mux_sel   = r_pc_mux_sel;
    assign bus.flg_shad_ld  = r_flg_shad_ld;
    assign bus.flg_clr      = r_flg_clr;

endmodule
`default_nettype wire

// File: tb/tb_int_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_sequencer
// Purpose  : Directed vector table plus multi-cycle sequences for int_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_save   = 0;

    always #5 clk = ~clk;

    int_sequencer_if bus ();

    int_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {cu_hold, scr_we, scr_data_sel, scr_addr_sel, sp_decr, pc_ld, pc_mux_sel, flg_shad_ld, flg_clr}
    logic [10:0] dp;
    assign dp = {bus.cu_hold, bus.scr_we, bus.scr_data_sel, bus.scr_addr_sel, bus.sp_decr,
                 bus.pc_ld, bus.pc_mux_sel, bus.flg_shad_ld, bus.flg_clr};

    localparam logic [10:0] DP_IDLE   = 11'b0_0_0_00_0_0_00_0_0;
    localparam logic [10:0] DP_SAVE   = 11'b1_1_1_11_1_0_00_1_0;
    localparam logic [10:0] DP_VECTOR = 11'b1_0_0_00_0_1_10_0_1;

    function automatic logic [10:0] dp_exp(input logic [1:0] ph);
        case (ph)
            2'd1:    return DP_SAVE;
            2'd2:    return DP_VECTOR;
            default: return DP_IDLE;
        endcase
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.scr_we === 1'b1) n_save++;
    endtask

    task automatic clear_inputs(input logic pin);
        bus.sei       = 1'b0;
        bus.cli       = 1'b0;
        bus.retie     = 1'b0;
        bus.exec_done = 1'b0;
        bus.intr_in   = pin;
    endtask

    task automatic do_reset(input logic pin);
        clear_inputs(pin);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
    endtask

    task automatic pulse_sei();   bus.sei = 1'b1;       tick(); bus.sei = 1'b0;       endtask
    task automatic pulse_retie(); bus.retie = 1'b1;     tick(); bus.retie = 1'b0;     endtask
    task automatic pulse_exec();  bus.exec_done = 1'b1; tick(); bus.exec_done = 1'b0; endtask

    // Row: {sei, cli, retie, exec_done, intr_in}, {int_en, int_pending}, phase
    typedef struct packed {
        logic       sei;
        logic       cli;
        logic       retie;
        logic       exec;
        logic       intr;
        logic       e_en;
        logic       e_pend;
        logic [1:0] e_ph;
    } vec_t;

    vec_t tbl [24];

    initial begin
        tbl[0]  = 9'b10000_10_00;
        tbl[1]  = 9'b00001_10_00;
        tbl[2]  = 9'b00001_10_00;
        tbl[3]  = 9'b00001_11_00;
        tbl[4]  = 9'b00001_11_00;
        tbl[5]  = 9'b00011_11_01;
        tbl[6]  = 9'b00001_10_10;
        tbl[7]  = 9'b00001_00_00;
        tbl[8]  = 9'b00000_00_00;
        tbl[9]  = 9'b00000_00_00;
        tbl[10] = 9'b00001_00_00;
        tbl[11] = 9'b00011_00_00;
        tbl[12] = 9'b00011_01_00;
        tbl[13] = 9'b00011_01_00;
        tbl[14] = 9'b01001_01_00;
        tbl[15] = 9'b10001_11_00;
        tbl[16] = 9'b00011_11_01;
        tbl[17] = 9'b10001_10_10;
        tbl[18] = 9'b00001_00_00;
        tbl[19] = 9'b10001_10_00;
        tbl[20] = 9'b11001_00_00;
        tbl[21] = 9'b00101_10_00;
        tbl[22] = 9'b00001_10_00;
        tbl[23] = 9'b00011_10_00;

        clear_inputs(1'b0);
        tick();
        chk_bit("reset_int_en", bus.int_en, 1'b0);
        chk_bit("reset_int_pending", bus.int_pending, 1'b0);
        chk_vec("reset_outputs", dp, DP_IDLE);

        // Table-driven pass
        do_reset(1'b0);
        for (int i = 0; i < 24; i++) begin
            bus.sei       = tbl[i].sei;
            bus.cli       = tbl[i].cli;
            bus.retie     = tbl[i].retie;
            bus.exec_done = tbl[i].exec;
            bus.intr_in   = tbl[i].intr;
            tick();
            chk_bit($sformatf("row%0d_int_en", i), bus.int_en, tbl[i].e_en);
            chk_bit($sformatf("row%0d_int_pending", i), bus.int_pending, tbl[i].e_pend);
            chk_vec($sformatf("row%0d_outputs", i), dp, dp_exp(tbl[i].e_ph));
        end

        // Asynchronous reset while in SAVE, plus pin-to-pending latency
        do_reset(1'b0);
        pulse_sei();
        bus.intr_in = 1'b1;
        tick();
        tick();
        chk_bit("latency_2cyc_pending", bus.int_pending, 1'b0);
        tick();
        chk_bit("latency_3cyc_pending", bus.int_pending, 1'b1);
        pulse_exec();
        chk_vec("save_before_reset", dp, DP_SAVE);
        reset = 1'b1;
        #1;
        chk_vec("async_reset_outputs", dp, DP_IDLE);
        chk_bit("async_reset_int_en", bus.int_en, 1'b0);
        chk_bit("async_reset_int_pending", bus.int_pending, 1'b0);

        // Pin already high at reset release must not request
        do_reset(1'b1);
        n_save = 0;
        pulse_sei();
        bus.exec_done = 1'b1;
        repeat (6) tick();
        bus.exec_done = 1'b0;
        chk_bit("high_at_release_pending", bus.int_pending, 1'b0);
        chk_int("high_at_release_sequences", n_save, 0);
        bus.intr_in = 1'b0;
        repeat (3) tick();
        bus.intr_in = 1'b1;
        repeat (3) tick();
        chk_bit("later_edge_pending", bus.int_pending, 1'b1);
        pulse_exec();
        repeat (3) tick();
        chk_int("later_edge_sequences", n_save, 1);

        // Edge landing in the same cycle SAVE clears pending
        pulse_sei();
        bus.intr_in = 1'b0;
        repeat (4) tick();
        bus.intr_in = 1'b1;
        repeat (3) tick();
        chk_bit("sbc_setup_pending", bus.int_pending, 1'b1);
        bus.intr_in = 1'b0;
        repeat (4) tick();
        bus.intr_in = 1'b1;
        tick();
        pulse_exec();
        chk_vec("sbc_save", dp, DP_SAVE);
        tick();
        chk_vec("sbc_vector", dp, DP_VECTOR);
        chk_bit("set_beats_clear_pending", bus.int_pending, 1'b1);
        tick();
        chk_bit("sbc_int_en_after", bus.int_en, 1'b0);
        chk_bit("sbc_pending_after", bus.int_pending, 1'b1);

        // Edge during VECTOR, retie + boundary, then collapsed masked edges
        do_reset(1'b0);
        n_save = 0;
        pulse_sei();
        bus.intr_in = 1'b1;
        repeat (3) tick();
        pulse_exec();
        bus.intr_in = 1'b0;
        tick();
        chk_vec("vec_edge_vector", dp, DP_VECTOR);
        bus.intr_in = 1'b1;
        tick();
        repeat (3) tick();
        chk_bit("vec_edge_pending", bus.int_pending, 1'b1);
        chk_bit("vec_edge_int_en", bus.int_en, 1'b0);
        chk_int("vec_edge_sequences", n_save, 1);
        pulse_retie();
        pulse_exec();
        repeat (3) tick();
        chk_int("retie_sequences", n_save, 2);
        chk_bit("retie_pending", bus.int_pending, 1'b0);
        chk_bit("retie_int_en", bus.int_en, 1'b0);
        repeat (3) begin
            bus.intr_in = 1'b0;
            tick();
            tick();
            bus.intr_in = 1'b1;
            tick();
            tick();
        end
        repeat (4) tick();
        pulse_exec();
        chk_bit("masked_three_pending", bus.int_pending, 1'b1);
        chk_int("masked_three_no_seq", n_save, 2);
        pulse_sei();
        pulse_exec();
        repeat (3) tick();
        chk_int("collapse_one_seq", n_save, 3);
        chk_bit("collapse_pending", bus.int_pending, 1'b0);
        pulse_sei();
        pulse_exec();
        repeat (3) tick();
        chk_int("collapse_no_extra", n_save, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
